// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data RAM behind a req/ready handshake.
// Each accepted access waits LATENCY cycles, then completes with a
// one-cycle ready pulse. The RAM is read or written on the edge that
// enters RESP.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, an access
// whose captured addr[1:0] is nonzero becomes a no-op and err pulses with
// ready. When it is undefined, the low address bits are ignored and err is 0.
module dmem_resp #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         AW       = DEPTH_LOG2 + 2;
    localparam logic [3:0] LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t          state, next_state;
    logic [3:0]      cnt, next_cnt;

    logic            cap_we;
    logic [AW-1:0]   cap_addr;
    logic [31:0]     cap_wdata;

    // Values used for the RAM access: live inputs when the access happens
    // on the capture edge (LATENCY=0), captured copies otherwise.
    logic            acc_we;
    logic [AW-1:0]   acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_ok;
    logic            commit;

    logic [31:0]     mem [2**DEPTH_LOG2];

    assign acc_we    = (state == IDLE) ? we          : cap_we;
    assign acc_addr  = (state == IDLE) ? addr[AW-1:0] : cap_addr;
    assign acc_wdata = (state == IDLE) ? wdata       : cap_wdata;

    // The access happens exactly on the edge that moves the FSM into RESP.
    assign commit = (next_state == RESP) && (state != RESP);

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_ok = (acc_addr[1:0] == 2'b00);
    assign err    = (state == RESP) && (cap_addr[1:0] != 2'b00);

    logic unused_bits;
    assign unused_bits = ^addr[31:AW];
`else
    assign acc_ok = 1'b1;
    assign err    = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{addr[31:AW], acc_addr[1:0], cap_addr[1:0]};
`endif

    // State and wait-state counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and counter logic.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request fields when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
        end else if (state == IDLE && req) begin
            cap_we    <= we;
            cap_addr  <= addr[AW-1:0];
            cap_wdata <= wdata;
        end
    end

    // Load result register; stores and no-op accesses leave it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'd0;
        end else if (commit && acc_ok && !acc_we) begin
            rdata <= mem[acc_addr[AW-1:2]];
        end
    end

    // RAM write port. A store committing while reset is held is suppressed.
    // NOTE: the RAM array has no reset; its contents survive reset and an
    // unwritten word reads as X.
    always_ff @(posedge clk) begin
        if (commit && acc_ok && acc_we && reset) begin
            mem[acc_addr[AW-1:2]] <= acc_wdata;
        end
    end

endmodule
